// File: rtl/clk_div3.sv
// ---------------------------------------------------------------------------
// clk_div3 -- integer clock divider with an exact 50% duty cycle.
//
// Divides clk by DIVISOR (default 3, legal range 2..65535). The output period
// is DIVISOR source periods, and the output is high for exactly half of it.
// Even divisors are built from rising-edge flops only. Odd divisors use one
// extra falling-edge flop to get the half-period resolution they need.
//
// Ports
//   clk      in   source clock; rising edge is primary, falling edge is used
//                 only when DIVISOR is odd
//   reset    in   synchronous active-high reset, sampled on the rising edge
//   clk_out  out  divided clock; driven by a flop, or by the OR of two flops
// ---------------------------------------------------------------------------
module clk_div3 #(
    parameter int DIVISOR = 3
) (
    input  logic clk,
    input  logic reset,
    output logic clk_out
);

    // Counter width; a 1-bit counter still covers DIVISOR == 2.
    localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
    // Number of rising edges per period during which the phase flop is high.
    localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR / 2);

    localparam bit IS_ODD = (DIVISOR % 2) == 1;

    // Reject divisors that do not fit the design at elaboration time.
    if ((DIVISOR < 2) || (DIVISOR > 65535)) begin : g_bad_divisor
        $error("clk_div3: DIVISOR must be in the range 2..65535");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          p_q;
    logic          p_d;

    // Next-state logic for the modulo-N counter and the rising-edge phase.
    always_comb begin
        cnt_d = cnt_q;
        p_d   = p_q;
        if (reset) begin
            cnt_d = CNT_ZERO;
            p_d   = 1'b0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            // The phase uses the counter value before this edge's update, so
            // the output rises on the same edge at which the counter leaves 0.
            p_d = (cnt_q < CNT_HALF);
        end
    end

    // Rising-edge state register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
        p_q   <= p_d;
    end

    if (IS_ODD) begin : g_odd
        logic n_q;

        // Half-cycle delayed copy of the phase. ORing it with the phase
        // stretches the high time by Tclk/2, giving N*Tclk/2 high for odd N.
        always_ff @(negedge clk) begin
            if (reset) begin
                n_q <= 1'b0;
            end else begin
                n_q <= p_q;
            end
        end

        // Both inputs are flops, and they never change together in a way
        // that can glitch: n_q only follows p_q half a cycle later.
        assign clk_out = p_q | n_q;
    end else begin : g_even
        assign clk_out = p_q;
    end

endmodule

// File: tb/tb_clk_div3.sv
// ---------------------------------------------------------------------------
// tb_clk_div3 -- self-checking bench for clk_div3 with divisors 2, 3, 4, 5.
//
// The output of every instance is sampled 1 ns after each clock edge (every
// half period). Expected levels come from a waveform model: counting
// half-cycles h from the first rising edge with reset low (E0), the output is
// high when (h mod 2N) < N. Expected levels are pushed to a queue when the
// reset level for the next cycle is driven, and popped at each sample.
// A table of reset/run segments drives the stimulus and holds the expected
// number of divide-by-3 rising edges per segment.
// ---------------------------------------------------------------------------
module tb_clk_div3;

    logic       clk;
    logic       reset;
    logic [3:0] out_s;

    clk_div3 #(.DIVISOR(2)) u_div2 (.clk(clk), .reset(reset), .clk_out(out_s[0]));
    clk_div3 #(.DIVISOR(3)) u_div3 (.clk(clk), .reset(reset), .clk_out(out_s[1]));
    clk_div3 #(.DIVISOR(4)) u_div4 (.clk(clk), .reset(reset), .clk_out(out_s[2]));
    clk_div3 #(.DIVISOR(5)) u_div5 (.clk(clk), .reset(reset), .clk_out(out_s[3]));

    // 10 ns source clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] exp;
        logic [3:0] care;
        int         tag;
    } sb_t;

    typedef struct {
        logic rst;
        int   cycles;
        int   rises3;
    } seg_t;

    sb_t  sb_q[$];
    seg_t segs[6];

    int  tests_run;
    int  tests_failed;
    int  sample_no;

    // Model state shared by all divisors (they all start at the same E0).
    bit  running;
    bit  was_running;
    bit  settled;
    int  h;

    // Push the expected levels for the next rising-edge and falling-edge
    // samples, given the reset level applied for this cycle.
    task automatic push_cycle(input logic r);
        sb_t e_pos;
        sb_t e_neg;
        int  n;
        e_pos.exp  = 4'b0000;
        e_pos.care = 4'b1111;
        e_neg.exp  = 4'b0000;
        e_neg.care = 4'b1111;
        e_pos.tag  = 2 * sample_no;
        e_neg.tag  = 2 * sample_no + 1;
        was_running = running;
        if (r) begin
            running = 1'b0;
            for (int i = 0; i < 4; i++) begin
                n = 2 + i;
                // Odd divisors: the falling-edge flop may still hold a 1 (a
                // shortened pulse) or X (before the first reset) for Tclk/2.
                if ((n % 2) == 1 && (was_running || !settled)) begin
                    e_pos.care[i] = 1'b0;
                end
            end
            settled = 1'b1;
        end else begin
            if (running) begin
                h = h + 1;
            end else begin
                h = 0;
                running = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                n = 2 + i;
                e_pos.exp[i] = ((h % (2 * n)) < n) ? 1'b1 : 1'b0;
            end
            h = h + 1;
            for (int i = 0; i < 4; i++) begin
                n = 2 + i;
                e_neg.exp[i] = ((h % (2 * n)) < n) ? 1'b1 : 1'b0;
            end
        end
        sb_q.push_back(e_pos);
        sb_q.push_back(e_neg);
        sample_no = sample_no + 1;
    endtask

    // Pop one expected record and compare it with the sampled outputs.
    task automatic check_sample();
        sb_t e;
        tests_run = tests_run + 1;
        if (sb_q.size() == 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL scoreboard_empty: got out=%b, required a queued expectation", out_s);
        end else begin
            e = sb_q.pop_front();
            if (((out_s ^ e.exp) & e.care) !== 4'b0000) begin
                tests_failed = tests_failed + 1;
                $display("FAIL sample_%0d at %0t: clk_out[N=5..2]=%b, required %b (care %b)",
                         e.tag, $time, out_s, e.exp, e.care);
            end
        end
    endtask

    // Watchdog: the run is a few thousand ns; anything far beyond is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic prev3;
        int   rises;
        tests_run    = 0;
        tests_failed = 0;
        sample_no    = 0;
        running      = 1'b0;
        was_running  = 1'b0;
        settled      = 1'b0;
        h            = 0;
        reset        = 1'b1;
        prev3        = 1'bx;

        // Reset/run segments with the expected number of N=3 rising edges.
        // The 52-cycle run ends so that the next reset edge hits N=3 mid-high.
        segs[0] = '{rst: 1'b1, cycles: 1,  rises3: 0};
        segs[1] = '{rst: 1'b0, cycles: 30, rises3: 10};
        segs[2] = '{rst: 1'b1, cycles: 1,  rises3: 0};
        segs[3] = '{rst: 1'b0, cycles: 52, rises3: 18};
        segs[4] = '{rst: 1'b1, cycles: 10, rises3: 0};
        segs[5] = '{rst: 1'b0, cycles: 60, rises3: 20};

        for (int s = 0; s < 6; s++) begin
            rises = 0;
            for (int c = 0; c < segs[s].cycles; c++) begin
                // Reset changes 1 ns after a falling edge, clear of the rising edge.
                reset = segs[s].rst;
                push_cycle(segs[s].rst);

                @(posedge clk);
                #1;
                check_sample();
                if (prev3 === 1'b0 && out_s[1] === 1'b1) rises = rises + 1;
                prev3 = out_s[1];
                if (segs[s].rst) begin
                    tests_run = tests_run + 1;
                    if (u_div3.cnt_q !== 2'd0) begin
                        tests_failed = tests_failed + 1;
                        $display("FAIL cnt_in_reset seg %0d cycle %0d: cnt=%0d, required 0",
                                 s, c, u_div3.cnt_q);
                    end
                end

                @(negedge clk);
                #1;
                check_sample();
                if (prev3 === 1'b0 && out_s[1] === 1'b1) rises = rises + 1;
                prev3 = out_s[1];
            end
            tests_run = tests_run + 1;
            if (rises != segs[s].rises3) begin
                tests_failed = tests_failed + 1;
                $display("FAIL rises3_seg%0d: counted %0d rising edges of N=3 output, required %0d",
                         s, rises, segs[s].rises3);
            end
        end

        // Every queued expectation must have been consumed.
        tests_run = tests_run + 1;
        if (sb_q.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL scoreboard_leftover: %0d entries left, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
